// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO result unit: FSM encoding, read-select codes
// and default timing parameters.
package hilo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } hilo_state_e;

   localparam logic RD_LO = 1'b0;
   localparam logic RD_HI = 1'b1;

   localparam int HILO_TIMEOUT_DEF = 40;
   localparam int HILO_CNT_W_DEF   = 6;

endpackage

// File: rtl/hilo_timeout_counter.sv
// Cycle counter for an in-flight mult/div; o_expired marks the last cycle the
// result may still arrive before the unit gives up.
module hilo_timeout_counter #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/hilo_result_unit.sv
// Owns architectural HI/LO: captures mult/div results over a valid/ready handshake,
// serves mfhi/mflo/mthi/mtlo, stalls HI/LO accesses while an operation is in flight.
module hilo_result_unit
   import hilo_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = HILO_TIMEOUT_DEF,
   parameter int CNT_W   = HILO_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_start,
   input  logic             op_is_div,
   input  logic             res_valid,
   input  logic [WIDTH-1:0] res_hi,
   input  logic [WIDTH-1:0] res_lo,
   input  logic             div_zero,
   output logic             res_ready,
   input  logic             mthi_we,
   input  logic             mtlo_we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_req,
   input  logic             rd_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             div0_exc,
   output logic             timeout_err,
   output hilo_state_e      dbg_state
);

   // Handshake: a result transfers on any edge where res_valid && res_ready;
   // res_ready is high for exactly the cycles spent in BUSY.

   hilo_state_e      r_state;
   hilo_state_e      w_state_nxt;
   logic             w_accept;
   logic             w_timeout;
   logic             w_busy;
   logic             w_stall;
   logic             w_expired;
   logic             w_start;
   logic             w_div0;
   logic             r_div_pending;
   logic             r_div0_exc;
   logic             r_timeout_err;
   logic             r_rd_valid;
   logic [WIDTH-1:0] r_rd_data;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   hilo_timeout_counter #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout_counter (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_start),
      .i_enable  (w_busy),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_timeout   = 1'b0;
      w_start     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (op_start) begin
               w_start     = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (res_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_expired) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_ERR;
            end
         end
         ST_ERR:  w_state_nxt = ST_ERR;
         default: w_state_nxt = ST_IDLE;
      endcase
      w_busy  = (r_state == ST_BUSY);
      w_stall = w_busy && (rd_req || mthi_we || mtlo_we);
      w_div0  = w_accept && r_div_pending && div_zero;
   end

   // All HI/LO accesses are stalled in BUSY, so result capture never races a write.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_div_pending <= 1'b0;
         r_div0_exc    <= 1'b0;
         r_timeout_err <= 1'b0;
         r_rd_valid    <= 1'b0;
         r_rd_data     <= '0;
         r_hi          <= '0;
         r_lo          <= '0;
      end else begin
         if (w_start) r_div_pending <= op_is_div;
         r_div0_exc <= w_div0;
         if (w_timeout) r_timeout_err <= 1'b1;
         r_rd_valid <= rd_req && !w_stall;
         if (rd_req && !w_stall) r_rd_data <= (rd_sel == RD_HI) ? r_hi : r_lo;
         if (w_accept) begin
            if (!w_div0) begin
               r_hi <= res_hi;
               r_lo <= res_lo;
            end
         end else begin
            if (mthi_we && !w_stall) r_hi <= wdata;
            if (mtlo_we && !w_stall) r_lo <= wdata;
         end
      end
   end

   assign res_ready   = w_busy;
   assign busy        = w_busy;
   assign stall       = w_stall;
   assign rd_data     = r_rd_data;
   assign rd_valid    = r_rd_valid;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign div0_exc    = r_div0_exc;
   assign timeout_err = r_timeout_err;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_hilo_result_unit.sv
// Directed bench for hilo_result_unit: read data checked through an expected queue,
// architectural state checked against a bench-side HI/LO model.
module tb_hilo_result_unit;
   import hilo_pkg::*;

   localparam int W = 32;

   logic          clk;
   logic          reset;
   logic          op_start, op_is_div, res_valid, div_zero;
   logic [W-1:0]  res_hi, res_lo, wdata;
   logic          res_ready, mthi_we, mtlo_we, rd_req, rd_sel;
   logic [W-1:0]  rd_data, hi, lo;
   logic          rd_valid, stall, busy, div0_exc, timeout_err;
   hilo_state_e   dbg_state;

   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  exp_hi, exp_lo;
   int            n_cmp, n_err;

   hilo_result_unit dut (
      .clk(clk), .reset(reset), .op_start(op_start), .op_is_div(op_is_div),
      .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo), .div_zero(div_zero),
      .res_ready(res_ready), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
      .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid),
      .stall(stall), .hi(hi), .lo(lo), .busy(busy), .div0_exc(div0_exc),
      .timeout_err(timeout_err), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every rd_valid pulse must match the oldest expected read.
   task automatic sample_reads();
      logic [W-1:0] e;
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("rd_spurious", 32'(rd_valid), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check("rd_data", rd_data, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      sample_reads();
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      op_start = 0; op_is_div = 0; res_valid = 0; div_zero = 0;
      res_hi = '0; res_lo = '0; wdata = '0;
      mthi_we = 0; mtlo_we = 0; rd_req = 0; rd_sel = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_hi = '0;
      exp_lo = '0;
      exp_q.delete();
   endtask

   initial begin
      int n;
      n_cmp = 0;
      n_err = 0;
      idle_inputs();
      do_reset();

      // Reset state
      check("rst_hi", hi, 32'(0));
      check("rst_lo", lo, 32'(0));
      check("rst_rd_data", rd_data, 32'(0));
      check("rst_rd_valid", 32'(rd_valid), 32'(0));
      check("rst_res_ready", 32'(res_ready), 32'(0));
      check("rst_stall", 32'(stall), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_div0", 32'(div0_exc), 32'(0));
      check("rst_tmo", 32'(timeout_err), 32'(0));
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

      // 1. MULT, result 5 cycles after op_start
      op_start = 1; op_is_div = 0;
      tick();
      op_start = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            res_valid = 1; res_hi = 32'hFFFF_FFFF; res_lo = 32'hFFFF_FFFE;
         end
         settle();
         check("mult_busy", 32'(busy), 32'(1));
         check("mult_ready", 32'(res_ready), 32'(1));
         tick();
      end
      res_valid = 0;
      exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFE;
      check("mult_busy_done", 32'(busy), 32'(0));
      check("mult_hi", hi, exp_hi);
      check("mult_lo", lo, exp_lo);
      rd_req = 1; rd_sel = RD_HI;
      exp_q.push_back(exp_hi);
      settle();
      check("mfhi_stall", 32'(stall), 32'(0));
      tick();
      rd_req = 0;

      // 2. DIV with zero divisor
      op_start = 1; op_is_div = 1;
      tick();
      op_start = 0; op_is_div = 0;
      tick();
      res_valid = 1; div_zero = 1; res_hi = 32'h0000_1234; res_lo = 32'h0000_5678;
      settle();
      check("div0_pre", 32'(div0_exc), 32'(0));
      tick();
      res_valid = 0; div_zero = 0;
      check("div0_pulse", 32'(div0_exc), 32'(1));
      check("div0_hi", hi, exp_hi);
      check("div0_lo", lo, exp_lo);
      check("div0_state", 32'(dbg_state), 32'(ST_IDLE));
      tick();
      check("div0_clear", 32'(div0_exc), 32'(0));

      // div_zero on a MULT result is ignored
      op_start = 1; op_is_div = 0;
      tick();
      op_start = 0;
      res_valid = 1; div_zero = 1; res_hi = 32'h1111_1111; res_lo = 32'h2222_2222;
      tick();
      res_valid = 0; div_zero = 0;
      exp_hi = 32'h1111_1111; exp_lo = 32'h2222_2222;
      check("multdz_div0", 32'(div0_exc), 32'(0));
      check("multdz_hi", hi, exp_hi);
      check("multdz_lo", lo, exp_lo);

      // 3. mfhi stalled across a BUSY window, completes after the accept
      op_start = 1;
      tick();
      op_start = 0;
      rd_req = 1; rd_sel = RD_HI;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("busy_rd_stall", 32'(stall), 32'(1));
         tick();
      end
      res_valid = 1; res_hi = 32'hCAFE_BABE; res_lo = 32'h0BAD_F00D;
      settle();
      check("accept_stall", 32'(stall), 32'(1));
      tick();
      res_valid = 0;
      exp_hi = 32'hCAFE_BABE; exp_lo = 32'h0BAD_F00D;
      exp_q.push_back(exp_hi);
      settle();
      check("post_accept_stall", 32'(stall), 32'(0));
      tick();
      rd_req = 0;
      check("rd_valid_drop", 32'(rd_valid), 32'(1));
      check("q_empty_3", 32'(exp_q.size()), 32'(0));

      // 5. Same-cycle mthi + mfhi returns the old value, then the new one
      mthi_we = 1; wdata = 32'hA5A5_A5A5; rd_req = 1; rd_sel = RD_HI;
      exp_q.push_back(exp_hi);
      tick();
      mthi_we = 0;
      exp_hi = 32'hA5A5_A5A5;
      exp_q.push_back(exp_hi);
      tick();
      // simultaneous mthi + mtlo with an mflo in the same cycle
      mthi_we = 1; mtlo_we = 1; wdata = 32'h5A5A_0F0F; rd_sel = RD_LO;
      exp_q.push_back(exp_lo);
      tick();
      mthi_we = 0; mtlo_we = 0;
      exp_hi = 32'h5A5A_0F0F; exp_lo = 32'h5A5A_0F0F;
      exp_q.push_back(exp_lo);
      tick();
      rd_req = 0;
      check("mtx_hi", hi, exp_hi);
      check("mtx_lo", lo, exp_lo);
      check("q_empty_5", 32'(exp_q.size()), 32'(0));

      // 4. Timeout: no result ever arrives
      op_start = 1;
      tick();
      op_start = 0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         if (n == 20) check("tmo_early", 32'(timeout_err), 32'(0));
         tick();
      end
      check("tmo_cycles", 32'(n), 32'(40));
      check("tmo_state", 32'(dbg_state), 32'(ST_ERR));
      check("tmo_flag", 32'(timeout_err), 32'(1));
      res_valid = 1; res_hi = 32'hDEAD_BEEF; res_lo = 32'hFEED_FACE;
      settle();
      check("err_ready", 32'(res_ready), 32'(0));
      tick();
      res_valid = 0;
      check("err_hi", hi, exp_hi);
      check("err_lo", lo, exp_lo);
      rd_req = 1; rd_sel = RD_HI; mtlo_we = 1; wdata = 32'h0000_0042;
      exp_q.push_back(exp_hi);
      settle();
      check("err_stall", 32'(stall), 32'(0));
      tick();
      rd_req = 0; mtlo_we = 0;
      exp_lo = 32'h0000_0042;
      check("err_mtlo", lo, exp_lo);
      tick();
      tick();
      check("tmo_sticky", 32'(timeout_err), 32'(1));
      check("q_empty_4", 32'(exp_q.size()), 32'(0));
      do_reset();
      check("tmo_reset", 32'(timeout_err), 32'(0));
      check("tmo_reset_state", 32'(dbg_state), 32'(ST_IDLE));

      // 6. op_start with same-cycle mtlo, then reset in BUSY cycle 2
      mtlo_we = 1; wdata = 32'h1357_9BDF; op_start = 1;
      tick();
      mtlo_we = 0; op_start = 0;
      exp_lo = 32'h1357_9BDF;
      check("start_mtlo", lo, exp_lo);
      check("start_busy", 32'(busy), 32'(1));
      tick();
      reset = 1; res_valid = 1; res_hi = 32'h7777_7777; res_lo = 32'h8888_8888;
      tick();
      reset = 0;
      exp_hi = '0; exp_lo = '0;
      check("midrst_hi", hi, exp_hi);
      check("midrst_lo", lo, exp_lo);
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_ready", 32'(res_ready), 32'(0));
      tick();
      res_valid = 0;
      check("late_res_hi", hi, exp_hi);
      check("late_res_lo", lo, exp_lo);
      check("late_res_state", 32'(dbg_state), 32'(ST_IDLE));
      check("q_empty_end", 32'(exp_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
